// File: rtl/cla_pkg.sv
// Shared types and constants for the carry-lookahead adder datapath.
// Latency: none (types, constants and a pure combine function only).
// Backpressure: not applicable.
package cla_pkg;

  // Default operand width of the CLA datapath.
  localparam int CLA_WIDTH = 4;

  // Single-bit propagate/generate pair, the element of the lookahead tree.
  typedef struct packed {
    logic p;
    logic g;
  } pg_bit_t;

  // Per-bit propagate/generate vectors handed to the lookahead carry unit.
  typedef struct packed {
    logic [CLA_WIDTH-1:0] p;
    logic [CLA_WIDTH-1:0] g;
  } pg_t;

  // Associative lookahead operator: combine a more-significant span (hi)
  // with the adjacent less-significant span (lo) into one span.
  function automatic pg_bit_t pg_combine(input pg_bit_t hi, input pg_bit_t lo);
    pg_bit_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage : cla_pkg

// File: rtl/pg_cell.sv
// Single-bit propagate/generate cell: p = a ^ b, g = a & b.
// Latency: purely combinational.
// Backpressure: none.
module pg_cell (
  input  logic a,
  input  logic b,
  output logic p,
  output logic g
);

  // Propagate is XOR so the downstream sum is simply p ^ carry; this also
  // makes p and g mutually exclusive per bit.
  assign p = a ^ b;
  assign g = a & b;

endmodule : pg_cell

// File: rtl/pgu.sv
// Propagate/generate unit: per-bit p/g plus group gp/gg for the next CLA level.
// Latency: one clock from an accepted operand pair to out_valid.
// Backpressure: none; accepts one operand pair every cycle.
module pgu
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] g,
  output logic             gp,
  output logic             gg
);

  // The group tree works on a power-of-two number of leaves; unused upper
  // leaves are padded with the identity element (p=1, g=0).
  localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;
  localparam int NLEAF  = 1 << LEVELS;

  logic [WIDTH-1:0] p_w;
  logic [WIDTH-1:0] g_w;
  logic             gp_w;
  logic             gg_w;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic             gp_q, gp_d;
  logic             gg_q, gg_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    pg_cell u_pg_cell (
      .a (a[i]),
      .b (b[i]),
      .p (p_w[i]),
      .g (g_w[i])
    );
  end

  // Balanced binary reduction tree of the lookahead operator: each level
  // halves the number of spans, so depth is log2(WIDTH) and nothing ripples.
  always_comb begin
    pg_bit_t node [NLEAF];
    for (int i = 0; i < NLEAF; i++) begin
      node[i].p = 1'b1;
      node[i].g = 1'b0;
    end
    for (int i = 0; i < WIDTH; i++) begin
      node[i].p = p_w[i];
      node[i].g = g_w[i];
    end
    // In-place reduction is safe: entry i is written only after entries
    // 2i and 2i+1 (both >= i) have been read on the same level.
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      for (int i = 0; i < NLEAF / 2; i++) begin
        if (i < (NLEAF >> (lvl + 1))) begin
          node[i] = pg_combine(node[2*i+1], node[2*i]);
        end
      end
    end
    gp_w = node[0].p;
    gg_w = node[0].g;
  end

  // Next-state: capture a fresh result on in_valid, otherwise hold the last
  // result so a/b are ignored (including X) while idle.
  always_comb begin
    out_valid_d = in_valid;
    p_d         = p_q;
    g_d         = g_q;
    gp_d        = gp_q;
    gg_d        = gg_q;
    if (in_valid) begin
      p_d  = p_w;
      g_d  = g_w;
      gp_d = gp_w;
      gg_d = gg_w;
    end
  end

  // Output registers; reset has priority over a same-cycle capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      p_q         <= '0;
      g_q         <= '0;
      gp_q        <= 1'b0;
      gg_q        <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      p_q         <= p_d;
      g_q         <= g_d;
      gp_q        <= gp_d;
      gg_q        <= gg_d;
    end
  end

  assign out_valid = out_valid_q;
  assign p         = p_q;
  assign g         = g_q;
  assign gp        = gp_q;
  assign gg        = gg_q;

endmodule : pgu

// File: tb/tb_pgu.sv
// Testbench for pgu: arithmetic reference model plus literal pinned vectors.
// Latency: expects each accepted pair one clock later.
// Backpressure: none; drives a new pair every cycle.
module tb_pgu;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic [W-1:0] p;
  logic [W-1:0] g;
  logic         gp;
  logic         gg;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Reference state: what the outputs must show after the last edge.
  logic         m_valid;
  logic [W-1:0] m_p;
  logic [W-1:0] m_g;
  logic         m_gp;
  logic         m_gg;

  pgu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .p         (p),
    .g         (g),
    .gp        (gp),
    .gg        (gg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: group generate is the carry out of a+b with no carry-in; group
  // propagate means every bit position differs; p/g are xor/and.
  always @(posedge clk) begin
    int unsigned sum;
    sum = int'(a) + int'(b);
    if (rst) begin
      m_valid <= 1'b0;
      m_p     <= '0;
      m_g     <= '0;
      m_gp    <= 1'b0;
      m_gg    <= 1'b0;
    end else if (in_valid) begin
      m_valid <= 1'b1;
      m_p     <= a ^ b;
      m_g     <= a & b;
      m_gp    <= ((a ^ b) == {W{1'b1}});
      m_gg    <= ((sum >> W) & 1) != 0;
    end else begin
      m_valid <= 1'b0;
    end
  end

  // Compare process: outputs are meaningful every cycle after the first reset.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("p", 32'(p), 32'(m_p));
      check("g", 32'(g), 32'(m_g));
      check("gp", 32'(gp), 32'(m_gp));
      check("gg", 32'(gg), 32'(m_gg));
      check("p_and_g", 32'(p & g), 32'd0);
    end
  end

  // Drive one cycle from just after a falling edge; return after the next
  // falling edge, when the registered result is stable.
  task automatic step(input logic r, input logic v, input logic [W-1:0] aa, input logic [W-1:0] bb);
    rst      = r;
    in_valid = v;
    a        = aa;
    b        = bb;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic v, input logic [W-1:0] ep,
                     input logic [W-1:0] eg, input logic egp, input logic egg);
    check(name, 32'({out_valid, p, g, gp, gg}), 32'({v, ep, eg, egp, egg}));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    @(negedge clk);

    step(1'b1, 1'b0, 4'h0, 4'h0);
    step(1'b1, 1'b0, 4'h0, 4'h0);
    lit("reset", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    chk_en = 1'b1;

    step(1'b0, 1'b1, 4'h0, 4'h0);
    lit("zeros", 1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'hF, 4'hF);
    lit("ff_ff", 1'b1, 4'h0, 4'hF, 1'b0, 1'b1);
    step(1'b0, 1'b1, 4'hF, 4'h0);
    lit("ff_00", 1'b1, 4'hF, 4'h0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 4'h0, 4'h3);
    lit("00_03", 1'b1, 4'h3, 4'h0, 1'b0, 1'b0);
    // p=1100 g=0011: p3&p2&g1 = 1, so the group generates.
    step(1'b0, 1'b1, 4'hF, 4'h3);
    lit("ff_03", 1'b1, 4'hC, 4'h3, 1'b0, 1'b1);

    step(1'b0, 1'b0, 4'bxxxx, 4'bxxxx);
    lit("hold1", 1'b0, 4'hC, 4'h3, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'h5, 4'hA);
    lit("hold2", 1'b0, 4'hC, 4'h3, 1'b0, 1'b1);

    step(1'b1, 1'b1, 4'hF, 4'hF);
    lit("rst_wins", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

    // Exhaustive back-to-back sweep of every operand pair.
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 1'b1, W'(i >> 4), W'(i & 15));
    end

    // Random traffic with idle gaps and occasional resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
           W'($urandom), W'($urandom));
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_pgu
